// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready word handshake into the UART transmitter
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic              TxValid;
    logic              TxReady;
    logic [DATA_W-1:0] TxData;
    modport master(output TxValid, TxData, input TxReady);
    modport slave(input TxValid, TxData, output TxReady);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a one-word holding register
module uart_tx_param #(
    parameter int DATA_W    = 8,
    parameter int OVS       = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Tick,
    uart_tx_param_if.slave s_if,
    output logic          Tx,
    output logic          TxBusy,
    output logic          TxDone
);
    localparam int TW = $clog2(OVS);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t            state, state_nx;
    logic [TW-1:0]     tcnt;
    logic [3:0]        bcnt;
    logic [DATA_W-1:0] hr, shift;
    logic              hr_full, par_bit, bit_end, last_bit, load, xfer, tx_d;
    assign xfer        = s_if.TxValid && !hr_full;
    assign bit_end     = Tick && state != IDLE && tcnt == TW'(OVS - 1);
    assign last_bit    = bit_end && bcnt == (state == DATA ? 4'(DATA_W - 1) : 4'(STOP_BITS - 1));
    // HR unloads either from idle or straight out of the last stop bit, giving gap-free frames
    assign load        = hr_full && (state == IDLE || (state == STOP && last_bit));
    assign s_if.TxReady = !hr_full;
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            state   <= IDLE;
            tcnt    <= '0;
            bcnt    <= '0;
            hr      <= '0;
            hr_full <= 1'b0;
            shift   <= '0;
            par_bit <= 1'b0;
            Tx      <= 1'b1;
            TxBusy  <= 1'b0;
            TxDone  <= 1'b0;
        end else begin
            state   <= state_nx;
            tcnt    <= bit_end || state_nx != state ? '0 : Tick && state != IDLE ? tcnt + 1'b1 : tcnt;
            bcnt    <= state_nx != state ? '0 : bit_end ? bcnt + 1'b1 : bcnt;
            hr_full <= xfer ? 1'b1 : load ? 1'b0 : hr_full;
            if (xfer) hr <= s_if.TxData;
            if (load) begin
                shift   <= hr;
                par_bit <= ^hr ^ (PARITY == 2);
            end else if (state == DATA && bit_end) shift <= shift >> 1;
            Tx      <= tx_d;
            TxBusy  <= state != IDLE || hr_full;
            TxDone  <= state == STOP && last_bit;
        end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = hr_full ? START : IDLE;
            START:   state_nx = bit_end ? DATA : START;
            DATA:    state_nx = last_bit ? (PARITY != 0 ? PAR : STOP) : DATA;
            PAR:     state_nx = bit_end ? STOP : PAR;
            default: state_nx = last_bit ? (hr_full ? START : IDLE) : STOP;
        endcase
    end
    always_comb
        tx_d = state == START ? 1'b0 : state == DATA ? shift[0] : state == PAR ? par_bit : 1'b1;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized frame checks of uart_tx_param against a tick-level line model
module tb_uart_tx_param;
    localparam int OVS = 16;
    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, ten = 1'b1;
    logic [3:0] v = '0, tx, dn, bz, rdy;
    logic [8:0] dat = '0;
    int         sel = 0, nchk = 0, nerr = 0, ndone = 0, tph = 0;
    bit         tick_prev = 1'b0, cap = 1'b0;
    bit         q[$], ex[$];
    int         dlen[$], eb[$];

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_W(8)) if0 ();
    uart_tx_param_if #(.DATA_W(7)) if1 ();
    uart_tx_param_if #(.DATA_W(7)) if2 ();
    uart_tx_param_if #(.DATA_W(8)) if3 ();
    assign if0.TxValid = v[0];
    assign if1.TxValid = v[1];
    assign if2.TxValid = v[2];
    assign if3.TxValid = v[3];
    assign if0.TxData  = dat[7:0];
    assign if1.TxData  = dat[6:0];
    assign if2.TxData  = dat[6:0];
    assign if3.TxData  = dat[7:0];
    assign rdy = {if3.TxReady, if2.TxReady, if1.TxReady, if0.TxReady};

    uart_tx_param d0 (.Clk(clk), .Rst(rst), .Tick(tick), .s_if(if0), .Tx(tx[0]), .TxBusy(bz[0]), .TxDone(dn[0]));
    uart_tx_param #(.DATA_W(7), .PARITY(1)) d1 (.Clk(clk), .Rst(rst), .Tick(tick), .s_if(if1), .Tx(tx[1]), .TxBusy(bz[1]), .TxDone(dn[1]));
    uart_tx_param #(.DATA_W(7), .PARITY(2)) d2 (.Clk(clk), .Rst(rst), .Tick(tick), .s_if(if2), .Tx(tx[2]), .TxBusy(bz[2]), .TxDone(dn[2]));
    uart_tx_param #(.STOP_BITS(2)) d3 (.Clk(clk), .Rst(rst), .Tick(tick), .s_if(if3), .Tx(tx[3]), .TxBusy(bz[3]), .TxDone(dn[3]));

    initial forever begin
        @(posedge clk);
        #1;
        tph  = (tph + 1) % 4;
        tick = ten && tph == 0;
    end

    // One line sample per tick, taken a cycle later; leading idle samples are dropped
    always @(negedge clk) begin
        if (cap && tick_prev && (q.size() > 0 || tx[sel] == 1'b0)) q.push_back(tx[sel]);
        if (cap && dn[sel]) begin
            ndone++;
            dlen.push_back(q.size());
        end
        tick_prev = tick;
    end

    task automatic clear(input int s);
        sel = s;
        cap = 1'b1;
        q.delete();
        ex.delete();
        dlen.delete();
        eb.delete();
        ndone = 0;
    endtask

    task automatic add_frame(input int dw, input int par, input int sb, input logic [8:0] d);
        bit p;
        p = 1'b0;
        for (int i = 0; i < OVS; i++) ex.push_back(1'b0);
        for (int b = 0; b < dw; b++) begin
            p ^= d[b];
            for (int i = 0; i < OVS; i++) ex.push_back(d[b]);
        end
        if (par != 0) for (int i = 0; i < OVS; i++) ex.push_back(par == 2 ? ~p : p);
        for (int i = 0; i < sb * OVS; i++) ex.push_back(1'b1);
        eb.push_back(ex.size());
    endtask

    task automatic send(input int s, input logic [8:0] d);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        v[s] = 1'b1;
        dat  = d;
        while (!rdy[s] && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        nchk++;
        if (n >= 3000) begin
            nerr++;
            $display("FAIL send_ready_timeout dut %0d ready %b want 1", s, rdy[s]);
        end
        @(posedge clk);
        #1;
        v[s] = 1'b0;
    endtask

    task automatic wait_samples(input int n);
        int c;
        c = 0;
        while (q.size() < n && c < 3000) begin
            @(negedge clk);
            #1;
            c++;
        end
        nchk++;
        if (q.size() < n) begin
            nerr++;
            $display("FAIL sample_timeout got %0d samples want %0d", q.size(), n);
        end
    endtask

    task automatic check_frames(input string nm);
        int n, bad, first, got;
        n = 0; bad = 0; first = -1;
        while (ndone < eb.size() && n < 8000) begin
            @(negedge clk);
            #1;
            n++;
        end
        nchk++;
        if (ndone < eb.size()) begin
            nerr++;
            $display("FAIL %s done_timeout got %0d pulses want %0d", nm, ndone, eb.size());
        end else begin
            nchk++;
            if (bz[sel] !== 1'b1) begin
                nerr++;
                $display("FAIL %s busy_at_done got %b want 1", nm, bz[sel]);
            end
            @(negedge clk);
            #1;
            nchk++;
            if (bz[sel] !== 1'b0) begin
                nerr++;
                $display("FAIL %s busy_after_done got %b want 0", nm, bz[sel]);
            end
        end
        for (int i = 0; i < eb.size(); i++) begin
            got = i < dlen.size() ? dlen[i] : -1;
            nchk++;
            if (got != eb[i]) begin
                nerr++;
                $display("FAIL %s done_tick frame %0d got %0d ticks want %0d", nm, i, got, eb[i]);
            end
        end
        for (int i = 0; i < ex.size(); i++)
            if (i >= q.size() || q[i] != ex[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        nchk++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL %s line_bits %0d wrong ticks, first at tick %0d got %0d want %0d", nm, bad,
                     first, first < q.size() ? int'(q[first]) : -1, int'(ex[first]));
        end
        repeat (100) @(negedge clk);
        #1;
        nchk++;
        if (ndone != eb.size()) begin
            nerr++;
            $display("FAIL %s done_count got %0d want %0d", nm, ndone, eb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        nchk++; if (tx !== 4'hF) begin nerr++; $display("FAIL reset_tx got %b want 1111", tx); end
        nchk++; if (rdy !== 4'hF) begin nerr++; $display("FAIL reset_ready got %b want 1111", rdy); end
        nchk++; if (bz !== 4'h0) begin nerr++; $display("FAIL reset_busy got %b want 0000", bz); end
        nchk++; if (dn !== 4'h0) begin nerr++; $display("FAIL reset_done got %b want 0000", dn); end
        rst = 1'b0;
    endtask

    task automatic test_default();
        clear(0);
        send(0, 9'h0A5);
        add_frame(8, 0, 1, 9'h0A5);
        check_frames("default_a5");
    endtask

    task automatic test_parity();
        clear(1);
        send(1, 9'h055);
        add_frame(7, 1, 1, 9'h055);
        check_frames("even_55");
        nchk++;
        if (q.size() <= 136 || q[136] !== 1'b0) begin
            nerr++;
            $display("FAIL even_parity_bit got %0d want 0", q.size() > 136 ? int'(q[136]) : -1);
        end
        clear(2);
        send(2, 9'h055);
        add_frame(7, 2, 1, 9'h055);
        check_frames("odd_55");
        nchk++;
        if (q.size() <= 136 || q[136] !== 1'b1) begin
            nerr++;
            $display("FAIL odd_parity_bit got %0d want 1", q.size() > 136 ? int'(q[136]) : -1);
        end
    endtask

    task automatic test_two_stop();
        clear(3);
        send(3, 9'h000);
        add_frame(8, 0, 2, 9'h000);
        check_frames("two_stop_00");
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        clear(0);
        send(0, 9'h000);
        send(0, 9'h0FF);
        add_frame(8, 0, 1, 9'h000);
        add_frame(8, 0, 1, 9'h0FF);
        nchk++; if (rdy[0] !== 1'b0) begin nerr++; $display("FAIL b2b_ready_full got %b want 0", rdy[0]); end
        repeat (300) @(negedge clk);
        #1;
        nchk++; if (rdy[0] !== 1'b0) begin nerr++; $display("FAIL b2b_ready_mid got %b want 0", rdy[0]); end
        while (ndone < 1 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        nchk++; if (rdy[0] !== 1'b1) begin nerr++; $display("FAIL b2b_ready_after_unload got %b want 1", rdy[0]); end
        check_frames("back_to_back");
    endtask

    task automatic test_reset_mid();
        logic [8:0] d;
        d = 9'($urandom_range(0, 255));
        clear(0);
        send(0, d);
        wait_samples(56);
        rst = 1'b1;
        #1;
        nchk++; if (tx[0] !== 1'b1) begin nerr++; $display("FAIL rst_mid_tx got %b want 1", tx[0]); end
        nchk++; if (bz[0] !== 1'b0) begin nerr++; $display("FAIL rst_mid_busy got %b want 0", bz[0]); end
        nchk++; if (rdy[0] !== 1'b1) begin nerr++; $display("FAIL rst_mid_ready got %b want 1", rdy[0]); end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        nchk++; if (ndone != 0) begin nerr++; $display("FAIL rst_mid_no_done got %0d pulses want 0", ndone); end
        clear(0);
        send(0, 9'h03C);
        add_frame(8, 0, 1, 9'h03C);
        check_frames("after_reset_3c");
    endtask

    task automatic test_tick_hold();
        logic [8:0] d;
        logic       t0;
        int         bad;
        bad = 0;
        d = 9'($urandom_range(0, 255));
        clear(0);
        send(0, d);
        add_frame(8, 0, 1, d);
        wait_samples(56);
        ten = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        t0 = tx[0];
        repeat (100) begin
            @(negedge clk);
            #1;
            if (tx[0] !== t0) bad++;
        end
        nchk++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL tick_hold_tx changed in %0d cycles got %b want %b", bad, tx[0], t0);
        end
        ten = 1'b1;
        check_frames("tick_hold");
    endtask

    task automatic test_random();
        logic [8:0] d;
        for (int s = 0; s < 4; s++) begin
            clear(s);
            for (int k = 0; k < 3; k++) begin
                d = 9'($urandom_range(0, 511));
                send(s, d);
                add_frame(s == 1 || s == 2 ? 7 : 8, s == 1 ? 1 : s == 2 ? 2 : 0, s == 3 ? 2 : 1, d);
            end
            check_frames($sformatf("random_dut%0d", s));
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid();
        test_tick_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
